mc_arbiter: RTL and testbench
=============================

MC_ARBITER -- requirements
Module: mc_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, BUSY-state watchdog limit in cycles, legal 2..65535, used only with ARB_TIMEOUT_EN.
REQ-002 SHALL have port: arb_clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: arb_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  in  4  per-requester request, bit i = core controller i.
REQ-005 SHALL have port: req_condition  in  12  per-requester 3-bit data condition, bits [3i+2:3i].
REQ-006 SHALL have port: req_length  in  24  per-requester 6-bit data length, bits [6i+5:6i].
REQ-007 SHALL have port: mc_done  in  1  memory controller transfer complete.
REQ-008 SHALL have port: mc_data_done  in  1  memory controller data set complete.
REQ-009 SHALL have port: mc_condition  out  3  registered condition driven to the memory controller.
REQ-010 SHALL have port: mc_length  out  6  registered length driven to the memory controller.
REQ-011 SHALL have port: grant  out  4  one-hot owner of the memory controller, 0 when free.
REQ-012 SHALL have port: grant_done  out  4  one-cycle completion pulse to the owner.
REQ-013 SHALL have port: arb_busy  out  1  high in BUSY and RELEASE.
REQ-014 SHALL have port: arb_timeout  out  1  one-cycle watchdog-release pulse.

Function
REQ-015 SHALL implement states IDLE, BUSY, RELEASE; encoding 2'b00, 2'b01, 2'b10; any other encoding goes to IDLE with all outputs cleared.
REQ-016 SHALL treat requester i as eligible when req_valid[i]=1 and its req_condition is not 3'b000.
REQ-017 SHALL, in IDLE with at least one eligible requester, select the winner round-robin starting from the priority pointer, then ascending index with wrap 3->0.
REQ-018 SHALL, on that edge, register grant=one-hot(winner), mc_condition and mc_length from the winner's slices, and enter BUSY, giving 1-cycle request-to-grant latency.
REQ-019 SHALL hold mc_condition, mc_length and grant constant throughout BUSY; requester input changes and req_valid deassertion during BUSY SHALL be ignored.
REQ-020 SHALL ignore mc_done and mc_data_done outside BUSY.
REQ-021 SHALL, in BUSY on mc_done or mc_data_done (either or both), enter RELEASE.
REQ-022 SHALL, in RELEASE, drive grant=0, mc_condition=3'b000 and mc_length=0, and pulse grant_done[owner]=1 for exactly one cycle.
REQ-023 SHALL, in RELEASE, set the priority pointer to (owner+1) mod 4, then return to IDLE; no arbitration occurs in RELEASE.
REQ-024 SHALL start the next grant no earlier than 2 cycles after the completing edge (RELEASE, then IDLE arbitration).
REQ-025 SHALL hold all outputs at reset values in IDLE when no requester is eligible.

Reset
REQ-026 SHALL, on arb_reset=1 at a clock edge, set state=IDLE, pointer=0, grant=0, grant_done=0, mc_condition=3'b000, mc_length=0, arb_busy=0, arb_timeout=0, and clear the watchdog counter.
REQ-027 SHALL abandon any in-flight grant on reset mid-BUSY without pulsing grant_done; reset SHALL take priority over all other inputs.

Configuration
REQ-028 SHALL compile the watchdog only when macro ARB_TIMEOUT_EN is defined.
REQ-029 SHALL, with ARB_TIMEOUT_EN, keep a 16-bit counter that clears on entry to BUSY and increments every BUSY cycle.
REQ-030 SHALL, with ARB_TIMEOUT_EN, enter RELEASE when the counter reaches TIMEOUT_CYCLES-1 without a completion, pulsing arb_timeout=1 together with grant_done[owner].
REQ-031 SHALL, with ARB_TIMEOUT_EN, give a completion on the same edge as the limit precedence over the watchdog, leaving arb_timeout=0.
REQ-032 SHALL, without ARB_TIMEOUT_EN, instantiate no counter, tie arb_timeout to 0 and hold BUSY indefinitely.

Verification
REQ-033 SHALL cover: single request, req_valid=4'b0100, cond 3'b100, len 6'd12 -> next cycle grant=4'b0100, mc_condition=3'b100, mc_length=12; mc_done -> RELEASE with grant_done=4'b0100 for 1 cycle.
REQ-034 SHALL cover: all four requesting continuously from reset -> grants in order 0,1,2,3,0, each starting 2 cycles after the previous mc_done edge.
REQ-035 SHALL cover: req_valid=4'b0011, req_condition[2:0]=3'b000 -> requester 1 granted and requester 0 never granted.
REQ-036 SHALL cover: mc_done and mc_data_done pulsed in IDLE, and req_valid dropped during BUSY -> no state change and grant held until completion.
REQ-037 SHALL cover: arb_reset asserted mid-BUSY -> next cycle all outputs 0, grant_done=0, and next arbitration starts from requester 0.
REQ-038 SHALL cover: ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mc_done -> RELEASE after 8 BUSY cycles with arb_timeout=1 and grant_done pulsed; without the macro, grant held for 100 cycles.

Source files
------------

// File: rtl/mc_arbiter.sv
// Round-robin arbiter granting four core controllers access to one memory controller.
// Optional BUSY watchdog compiled in with `define ARB_TIMEOUT_EN.
module mc_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        arb_clk,
    input  logic        arb_reset,
    input  logic [3:0]  req_valid,
    input  logic [11:0] req_condition,
    input  logic [23:0] req_length,
    input  logic        mc_done,
    input  logic        mc_data_done,
    output logic [2:0]  mc_condition,
    output logic [5:0]  mc_length,
    output logic [3:0]  grant,
    output logic [3:0]  grant_done,
    output logic        arb_busy,
    output logic        arb_timeout
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] BUSY    = 2'b01;
    localparam logic [1:0] RELEASE = 2'b10;

    logic [1:0] state, state_nxt;
    logic [1:0] ptr, ptr_d;
    logic [1:0] owner, owner_d;
    logic [3:0] elig;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    logic       done_any;
    logic       wd_hit;

    logic [2:0] cond_d;
    logic [5:0] len_d;
    logic [3:0] grant_d;
    logic [3:0] gdone_d;
    logic       busy_d;
    logic       tmo_d;

    assign done_any = mc_done | mc_data_done;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = req_valid[i] && (req_condition[3*i +: 3] != 3'b000);
        end
    end

    // Scan from the pointer upward, wrapping 3 -> 0.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign wd_hit = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge arb_clk) begin
        if (arb_reset) begin
            wd_cnt <= '0;
        end else if (state == IDLE && found) begin
            wd_cnt <= '0;
        end else if (state == BUSY) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYCLES > 1);
    assign wd_hit     = 1'b0;
`endif

    always_ff @(posedge arb_clk) begin
        if (arb_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = found ? BUSY : IDLE;
            BUSY:    state_nxt = (done_any || wd_hit) ? RELEASE : BUSY;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant;
        cond_d  = mc_condition;
        len_d   = mc_length;
        gdone_d = 4'b0000;
        busy_d  = arb_busy;
        tmo_d   = 1'b0;
        ptr_d   = ptr;
        owner_d = owner;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_d = 4'b0001 << win;
                    cond_d  = req_condition[3*win +: 3];
                    len_d   = req_length[6*win +: 6];
                    busy_d  = 1'b1;
                    owner_d = win;
                end else begin
                    grant_d = 4'b0000;
                    cond_d  = 3'b000;
                    len_d   = 6'd0;
                    busy_d  = 1'b0;
                end
            end
            BUSY: begin
                if (done_any || wd_hit) begin
                    grant_d = 4'b0000;
                    cond_d  = 3'b000;
                    len_d   = 6'd0;
                    gdone_d = 4'b0001 << owner;
                    tmo_d   = wd_hit && !done_any;
                end
            end
            RELEASE: begin
                grant_d = 4'b0000;
                cond_d  = 3'b000;
                len_d   = 6'd0;
                busy_d  = 1'b0;
                ptr_d   = owner + 2'd1;
            end
            default: begin
                grant_d = 4'b0000;
                cond_d  = 3'b000;
                len_d   = 6'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge arb_clk) begin
        if (arb_reset) begin
            grant        <= 4'b0000;
            mc_condition <= 3'b000;
            mc_length    <= 6'd0;
            grant_done   <= 4'b0000;
            arb_busy     <= 1'b0;
            arb_timeout  <= 1'b0;
            ptr          <= 2'd0;
            owner        <= 2'd0;
        end else begin
            grant        <= grant_d;
            mc_condition <= cond_d;
            mc_length    <= len_d;
            grant_done   <= gdone_d;
            arb_busy     <= busy_d;
            arb_timeout  <= tmo_d;
            ptr          <= ptr_d;
            owner        <= owner_d;
        end
    end

endmodule

// File: tb/tb_mc_arbiter.sv
// Self-checking bench for mc_arbiter: directed cases plus randomized
// transactions scored against a transaction-level round-robin model.
module tb_mc_arbiter;

    logic        arb_clk = 1'b0;
    logic        arb_reset;
    logic [3:0]  req_valid;
    logic [11:0] req_condition;
    logic [23:0] req_length;
    logic        mc_done;
    logic        mc_data_done;
    logic [2:0]  mc_condition;
    logic [5:0]  mc_length;
    logic [3:0]  grant;
    logic [3:0]  grant_done;
    logic        arb_busy;
    logic        arb_timeout;

    int checks = 0;
    int errors = 0;
    int ptr    = 0;

    mc_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .arb_clk       (arb_clk),
        .arb_reset     (arb_reset),
        .req_valid     (req_valid),
        .req_condition (req_condition),
        .req_length    (req_length),
        .mc_done       (mc_done),
        .mc_data_done  (mc_data_done),
        .mc_condition  (mc_condition),
        .mc_length     (mc_length),
        .grant         (grant),
        .grant_done    (grant_done),
        .arb_busy      (arb_busy),
        .arb_timeout   (arb_timeout)
    );

    always #5 arb_clk = ~arb_clk;

    task automatic tick();
        @(posedge arb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_gdone"}, 32'(grant_done), 32'h0);
        chk({tag, "_cond"}, 32'(mc_condition), 32'h0);
        chk({tag, "_len"}, 32'(mc_length), 32'h0);
        chk({tag, "_busy"}, 32'(arb_busy), 32'h0);
        chk({tag, "_tmo"}, 32'(arb_timeout), 32'h0);
    endtask

    // Model: first eligible requester at or after the pointer, mod 4.
    function automatic int pick(input logic [3:0] v, input logic [11:0] c);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (v[i] && c[3*i +: 3] != 3'b000) return i;
        end
        return -1;
    endfunction

    task automatic do_grant(input logic [3:0] v, input logic [11:0] c,
                            input logic [23:0] l, output int w,
                            output logic [2:0] ec, output logic [5:0] el);
        req_valid     = v;
        req_condition = c;
        req_length    = l;
        w  = pick(v, c);
        ec = 3'b000;
        el = 6'd0;
        tick();
        if (w >= 0) begin
            ec = c[3*w +: 3];
            el = l[6*w +: 6];
            chk("grant", 32'(grant), 32'(4'b0001 << w));
            chk("cond", 32'(mc_condition), 32'(ec));
            chk("len", 32'(mc_length), 32'(el));
            chk("busy", 32'(arb_busy), 32'h1);
            chk("gdone_busy", 32'(grant_done), 32'h0);
        end else begin
            chk_idle("noreq");
        end
    endtask

    task automatic hold(input int n, input int w, input logic [2:0] ec,
                        input logic [5:0] el, input bit scramble);
        for (int k = 0; k < n; k++) begin
            if (scramble) begin
                req_valid     = 4'($urandom);
                req_condition = 12'($urandom);
                req_length    = 24'($urandom);
            end
            tick();
            chk("hold_grant", 32'(grant), 32'(4'b0001 << w));
            chk("hold_cond", 32'(mc_condition), 32'(ec));
            chk("hold_len", 32'(mc_length), 32'(el));
        end
    endtask

    task automatic release_owner(input logic [1:0] dn, input int w,
                                 input logic etmo);
        mc_done      = dn[0];
        mc_data_done = dn[1];
        tick();
        mc_done      = 1'b0;
        mc_data_done = 1'b0;
        chk("rel_grant", 32'(grant), 32'h0);
        chk("rel_cond", 32'(mc_condition), 32'h0);
        chk("rel_len", 32'(mc_length), 32'h0);
        chk("rel_gdone", 32'(grant_done), 32'(4'b0001 << w));
        chk("rel_busy", 32'(arb_busy), 32'h1);
        chk("rel_tmo", 32'(arb_timeout), 32'(etmo));
        tick();
        chk("post_grant", 32'(grant), 32'h0);
        chk("post_gdone", 32'(grant_done), 32'h0);
        chk("post_busy", 32'(arb_busy), 32'h0);
        chk("post_tmo", 32'(arb_timeout), 32'h0);
        ptr = (w + 1) % 4;
    endtask

    initial begin
        int w;
        logic [2:0] ec;
        logic [5:0] el;

        arb_reset     = 1'b1;
        req_valid     = 4'b0000;
        req_condition = 12'h000;
        req_length    = 24'h0;
        mc_done       = 1'b0;
        mc_data_done  = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        arb_reset = 1'b0;

        // Single request from requester 2.
        do_grant(4'b0100, 12'b000_100_000_000, {6'd0, 6'd12, 6'd0, 6'd0},
                 w, ec, el);
        chk("single_winner", 32'(w), 32'd2);
        hold(2, w, ec, el, 1'b0);
        release_owner(2'b01, w, 1'b0);

        // Continuous requests from reset: 0,1,2,3,0.
        arb_reset = 1'b1;
        tick();
        arb_reset = 1'b0;
        ptr = 0;
        for (int n = 0; n < 5; n++) begin
            do_grant(4'b1111, 12'b111_011_010_001,
                     {6'd40, 6'd30, 6'd20, 6'd10}, w, ec, el);
            chk("rr_order", 32'(w), 32'(n % 4));
            hold(1, w, ec, el, 1'b0);
            release_owner(2'b01, w, 1'b0);
        end

        // Requester 0 has a zero condition and is never eligible.
        for (int n = 0; n < 3; n++) begin
            do_grant(4'b0011, 12'b000_000_101_000, 24'h00_0fff, w, ec, el);
            chk("cond0_winner", 32'(w), 32'd1);
            release_owner(2'b10, w, 1'b0);
        end

        // Completion strobes outside BUSY are ignored.
        req_valid    = 4'b0000;
        mc_done      = 1'b1;
        tick();
        chk_idle("idle_done");
        mc_done      = 1'b0;
        mc_data_done = 1'b1;
        tick();
        chk_idle("idle_ddone");
        mc_data_done = 1'b0;

        // Request dropped during BUSY: grant holds until completion.
        do_grant(4'b1000, 12'b110_000_000_000, {6'd63, 18'd0}, w, ec, el);
        req_valid = 4'b0000;
        hold(4, w, ec, el, 1'b0);
        release_owner(2'b11, w, 1'b0);

        // Reset mid-BUSY abandons the grant without a completion pulse.
        do_grant(4'b0100, 12'b000_010_000_000, {6'd0, 6'd5, 12'd0}, w, ec, el);
        arb_reset = 1'b1;
        mc_done   = 1'b1;
        tick();
        chk_idle("rst_busy");
        arb_reset = 1'b0;
        mc_done   = 1'b0;
        ptr = 0;
        do_grant(4'b1111, 12'b001_001_001_001, 24'h123456, w, ec, el);
        chk("rst_ptr", 32'(w), 32'd0);
        release_owner(2'b01, w, 1'b0);

`ifdef ARB_TIMEOUT_EN
        do_grant(4'b0010, 12'b000_000_011_000, {12'd0, 6'd9, 6'd0}, w, ec, el);
        hold(7, w, ec, el, 1'b0);
        chk("wd_no_tmo", 32'(arb_timeout), 32'h0);
        release_owner(2'b00, w, 1'b1);
        do_grant(4'b0010, 12'b000_000_011_000, {12'd0, 6'd9, 6'd0}, w, ec, el);
        hold(7, w, ec, el, 1'b0);
        release_owner(2'b01, w, 1'b0);
`else
        do_grant(4'b0010, 12'b000_000_011_000, {12'd0, 6'd9, 6'd0}, w, ec, el);
        hold(100, w, ec, el, 1'b0);
        chk("no_wd_busy", 32'(arb_busy), 32'h1);
        chk("no_wd_tmo", 32'(arb_timeout), 32'h0);
        release_owner(2'b01, w, 1'b0);
`endif

        // Randomized transactions against the model.
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  v;
            logic [11:0] c;
            logic [23:0] l;
            v = 4'($urandom);
            c = 12'($urandom);
            l = 24'($urandom);
            do_grant(v, c, l, w, ec, el);
            if (w >= 0) begin
                hold($urandom_range(0, 5), w, ec, el, 1'b1);
                release_owner(2'($urandom_range(1, 3)), w, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
